// File: rtl/oam_pkg.sv
// Shared definitions for the operand/multiply stages: FSM state codes and default widths.
package oam_pkg;

  localparam int unsigned OAM_WIDTH = 32;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/seq_mult_stage_if.sv
// Operand/product handshake bundle for seq_mult_stage. slave = the multiplier, master = its
// environment (upstream operand source plus downstream product sink).
interface seq_mult_stage_if
  import oam_pkg::*;
#(
  parameter int unsigned WIDTH = OAM_WIDTH
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH/2-1:0] a;
  logic [WIDTH/2-1:0] b;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   product;

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product
  );

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product
  );
endinterface

// File: rtl/seq_mult_datapath.sv
// Shift-add datapath: shifted multiplicand, multiplier shifter and accumulator.
// Macro APPROX_TRUNC_EN clears the low TRUNC_BITS of every partial product.
module seq_mult_datapath
  import oam_pkg::*;
#(
  parameter int unsigned WIDTH      = OAM_WIDTH,
  parameter int unsigned TRUNC_BITS = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load,
  input  logic               i_step,
  input  logic [WIDTH/2-1:0] i_a,
  input  logic [WIDTH/2-1:0] i_b,
  output logic [WIDTH-1:0]   o_acc
);
  localparam int unsigned N = WIDTH / 2;

`ifdef APPROX_TRUNC_EN
  localparam bit TruncEn = 1'b1;
`else
  localparam bit TruncEn = 1'b0;
`endif

  localparam logic [WIDTH-1:0] TruncMask = ~((WIDTH'(1) << TRUNC_BITS) - WIDTH'(1));

  logic [WIDTH-1:0] r_a_sh;
  logic [N-1:0]     r_b_sh;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] w_pp;

  assign w_pp  = TruncEn ? (r_a_sh & TruncMask) : r_a_sh;
  assign o_acc = r_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh <= '0;
      r_b_sh <= '0;
      r_acc  <= '0;
    end else if (i_load) begin
      r_a_sh <= WIDTH'(i_a);
      r_b_sh <= i_b;
      r_acc  <= '0;
    end else if (i_step) begin
      // Exact N x N product fits in WIDTH bits, so the sum cannot overflow.
      if (r_b_sh[0]) r_acc <= r_acc + w_pp;
      r_a_sh <= r_a_sh << 1;
      r_b_sh <= r_b_sh >> 1;
    end
  end
endmodule

// File: rtl/seq_mult_stage.sv
// Iterative radix-2 unsigned multiplier, one op in flight, fixed N-cycle latency.
// Macro APPROX_TRUNC_EN selects the truncated (approximate) partial-product build.
module seq_mult_stage
  import oam_pkg::*;
#(
  parameter int unsigned WIDTH      = OAM_WIDTH,
  parameter int unsigned TRUNC_BITS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  seq_mult_stage_if.slave   bus
);
  localparam int unsigned N     = WIDTH / 2;
  localparam int unsigned CNT_W = $clog2(N);

  logic [1:0]       r_state;
  logic [1:0]       w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic             w_accept;
  logic             w_step;
  logic             w_last;
  logic [WIDTH-1:0] w_acc;

  assign w_accept = (r_state == S_IDLE) && bus.in_valid;
  assign w_step   = (r_state == S_CALC);
  assign w_last   = (r_cnt == CNT_W'(N - 1));

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.in_valid) w_state_next = S_CALC;
      S_CALC:  if (w_last) w_state_next = S_DONE;
      S_DONE:  if (bus.out_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) r_cnt <= '0;
      else if (w_step) r_cnt <= r_cnt + 1'b1;
    end
  end

  seq_mult_datapath #(
    .WIDTH      (WIDTH),
    .TRUNC_BITS (TRUNC_BITS)
  ) u_datapath (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_accept),
    .i_step (w_step),
    .i_a    (bus.a),
    .i_b    (bus.b),
    .o_acc  (w_acc)
  );

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.product   = w_acc;
endmodule

// File: tb/tb_seq_mult_stage.sv
// Scoreboard bench for seq_mult_stage: driver pushes expected products, monitor pops on output.
module tb_seq_mult_stage;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned TB_TRUNC = 8;
  localparam int unsigned N = WIDTH / 2;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  int   cyc;

  logic [WIDTH-1:0] exp_q[$];
  int               acc_q[$];

  seq_mult_stage_if #(.WIDTH(WIDTH)) bus ();

  seq_mult_stage #(
    .WIDTH      (WIDTH),
    .TRUNC_BITS (TB_TRUNC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: long multiplication, optionally dropping low bits of each partial product.
  function automatic logic [WIDTH-1:0] model(input logic [N-1:0] x, input logic [N-1:0] y);
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] term;
    sum = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (y[i]) begin
        term = WIDTH'(x) << i;
`ifdef APPROX_TRUNC_EN
        term = (term >> TB_TRUNC) << TB_TRUNC;
`endif
        sum = sum + term;
      end
    end
    return sum;
  endfunction

  // Monitor: compare every presented product against the scoreboard head.
  initial begin
    logic prev_ov;
    prev_ov = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_ov = 1'b0;
      end else begin
        if (bus.out_valid) begin
          if (exp_q.size() == 0) begin
            check("unexpected_out_valid", 1'b1, 1'b0);
          end else begin
            check("product", bus.product, exp_q[0]);
            if (!prev_ov) check("latency", WIDTH'(cyc - acc_q[0]), WIDTH'(N));
            if (bus.out_ready) begin
              void'(exp_q.pop_front());
              void'(acc_q.pop_front());
            end
          end
        end
        prev_ov = bus.out_valid;
      end
    end
  end

  task automatic wait_idle();
    int t;
    t = 0;
    while (!bus.in_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (!bus.in_ready) check("idle_timeout", 1'b0, 1'b1);
  endtask

  task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tb,
                        input int hold, input bit pulse);
    int t;
    wait_idle();
    bus.a         = ta;
    bus.b         = tb;
    bus.in_valid  = 1'b1;
    bus.out_ready = (hold == 0);
    exp_q.push_back(model(ta, tb));
    acc_q.push_back(cyc + 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    for (int i = 0; i < int'(N) - 1; i++) begin
      if (pulse && i == 3) begin
        bus.a        = N'($urandom);
        bus.b        = N'($urandom);
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      check("calc_handshake", {bus.in_ready, bus.out_valid}, 2'b00);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    t = 0;
    while (!bus.out_valid && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!bus.out_valid) begin
      check("out_valid_timeout", 1'b0, 1'b1);
    end else begin
      if (hold > 0) begin
        repeat (hold) begin
          @(posedge clk); #1;
        end
        check("hold_valid", bus.out_valid, 1'b1);
        bus.out_ready = 1'b1;
      end
      @(posedge clk); #1;
      check("turnaround", {bus.out_valid, bus.in_ready}, 2'b01);
    end
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", bus.in_ready, 1'b1);
    check("reset_out_valid", bus.out_valid, 1'b0);
    check("reset_product", bus.product, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(16'd3, 16'd5, 0, 1'b0);
    run_op(16'hFFFF, 16'hFFFF, 0, 1'b0);
    run_op(16'h1234, 16'h0010, 20, 1'b0);
    run_op(16'h00AB, 16'h0101, 0, 1'b1);
    run_op(16'h00FF, 16'h0001, 0, 1'b0);
    run_op(16'h00FF, 16'h0002, 0, 1'b0);
    run_op(16'h0000, 16'hFFFF, 0, 1'b0);

    // Abort an operation at cnt=7; its result must never appear.
    wait_idle();
    bus.a        = 16'h7777;
    bus.b        = 16'h3333;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (7) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", bus.out_valid, 1'b0);
    check("abort_in_ready", bus.in_ready, 1'b1);
    check("abort_product", bus.product, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_op(16'd2, 16'd2, 0, 1'b0);

    for (int k = 0; k < 20; k++) begin
      run_op(N'($urandom), N'($urandom), int'($urandom_range(0, 3)), (k % 4) == 0);
    end

    repeat (3) @(posedge clk);
    check("scoreboard_drain", WIDTH'(exp_q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
